eth_phy_prbs_test_ctrl: RTL and testbench

- Bring-up and BER-test sequencer for eth_phy_10g, running in the PHY receive clock domain.
- Holds the PHY in reset, releases it and waits for rx_block_lock.
- Then enables PRBS31 on TX and RX, discards a settling interval, and accumulates rx_error_count over a fixed block window.
- Reports pass/fail, total errors and lock acquisition time to test firmware or a bench.

---
 rtl/eth_phy_prbs_test_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_eth_phy_prbs_test_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/eth_phy_prbs_test_ctrl.sv
`default_nettype none
// ============================================================================
// eth_phy_prbs_test_ctrl : eth_phy_10g bring-up and PRBS31 BER test sequencer.
// Optional macro PRBS_CTRL_EARLY_STOP_EN ends MEASURE once errors pass ERR_LIMIT.
// Revision : 1.0
// ============================================================================
module eth_phy_prbs_test_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int SETTLE_CYCLES = 64,
    parameter int WINDOW_BLOCKS = 65536,
    parameter int ERR_LIMIT     = 0,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                   rx_clk,
    input  logic                   rx_rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   rx_block_lock,
    input  logic                   rx_high_ber,
    input  logic [6:0]             rx_error_count,
    output logic                   phy_tx_rst,
    output logic                   phy_rx_rst,
    output logic                   cfg_tx_prbs31_enable,
    output logic                   cfg_rx_prbs31_enable,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [2:0]             fail_code,
    output logic [COUNT_WIDTH-1:0] err_total,
    output logic [15:0]            lock_cycles
);

    localparam int                     SUM_W       = COUNT_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] C_ERR_LIMIT = COUNT_WIDTH'(ERR_LIMIT);
    localparam logic [2:0] C_FC_NONE    = 3'd0;
    localparam logic [2:0] C_FC_LOCK_TO = 3'd1;
    localparam logic [2:0] C_FC_LOST    = 3'd2;
    localparam logic [2:0] C_FC_ERRLIM  = 3'd3;
    localparam logic [2:0] C_FC_ABORT   = 3'd4;
    localparam logic [2:0] C_FC_HIGHBER = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_SETTLE    = 3'd3,
        S_MEASURE   = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] err_total_q, err_total_d;
    logic [15:0]            lock_cycles_q, lock_cycles_d;
    logic [2:0]             fail_code_q, fail_code_d;
    logic                   pass_q, pass_d;
    logic                   phy_rst_q, phy_rst_d;
    logic                   prbs_q, prbs_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [SUM_W-1:0]       sum_full;
    logic [COUNT_WIDTH-1:0] err_next;

    // One extra carry bit lets the accumulator clamp instead of wrapping.
    always_comb begin
        sum_full = {1'b0, err_total_q} + SUM_W'(rx_error_count);
        err_next = sum_full[COUNT_WIDTH] ? '1 : sum_full[COUNT_WIDTH-1:0];
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_total_d   = err_total_q;
        lock_cycles_d = lock_cycles_q;
        fail_code_d   = fail_code_q;
        pass_d        = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d       = S_RESET;
                    cnt_d         = 32'(RST_CYCLES - 1);
                    err_total_d   = '0;
                    lock_cycles_d = '0;
                    fail_code_d   = C_FC_NONE;
                    pass_d        = 1'b0;
                end
            end
            S_RESET: begin
                if (cnt_q == 32'd0) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_cycles_q != 16'hFFFF) begin
                    lock_cycles_d = lock_cycles_q + 16'd1;
                end
                if (rx_block_lock) begin
                    state_d = S_SETTLE;
                    cnt_d   = 32'(SETTLE_CYCLES - 1);
                end else if (cnt_q == 32'(LOCK_TIMEOUT - 1)) begin
                    state_d     = S_DONE;
                    fail_code_d = C_FC_LOCK_TO;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_SETTLE: begin
                if (!rx_block_lock) begin
                    state_d     = S_DONE;
                    fail_code_d = C_FC_LOST;
                end else if (cnt_q == 32'd0) begin
                    state_d = S_MEASURE;
                    cnt_d   = 32'(WINDOW_BLOCKS - 1);
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_MEASURE: begin
                err_total_d = err_next;
                if (!rx_block_lock) begin
                    state_d     = S_DONE;
                    fail_code_d = C_FC_LOST;
                end else if (rx_high_ber) begin
                    state_d     = S_DONE;
                    fail_code_d = C_FC_HIGHBER;
                end else if (cnt_q == 32'd0) begin
                    state_d = S_DONE;
                    if (err_next <= C_ERR_LIMIT) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_code_d = C_FC_ERRLIM;
                    end
`ifdef PRBS_CTRL_EARLY_STOP_EN
                end else if (err_next > C_ERR_LIMIT) begin
                    state_d     = S_DONE;
                    fail_code_d = C_FC_ERRLIM;
`endif
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every decision made above while a test is running.
        if (abort && (state_q inside {S_RESET, S_WAIT_LOCK, S_SETTLE, S_MEASURE})) begin
            state_d     = S_DONE;
            cnt_d       = cnt_q;
            err_total_d = err_total_q;
            fail_code_d = C_FC_ABORT;
            pass_d      = 1'b0;
        end

        phy_rst_d = (state_d == S_IDLE) || (state_d == S_RESET);
        prbs_d    = (state_d == S_SETTLE) || (state_d == S_MEASURE);
        busy_d    = state_d inside {S_RESET, S_WAIT_LOCK, S_SETTLE, S_MEASURE};
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            err_total_q   <= '0;
            lock_cycles_q <= '0;
            fail_code_q   <= C_FC_NONE;
            pass_q        <= 1'b0;
            phy_rst_q     <= 1'b1;
            prbs_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_total_q   <= err_total_d;
            lock_cycles_q <= lock_cycles_d;
            fail_code_q   <= fail_code_d;
            pass_q        <= pass_d;
            phy_rst_q     <= phy_rst_d;
            prbs_q        <= prbs_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign phy_tx_rst           = phy_rst_q;
    assign phy_rx_rst           = phy_rst_q;
    assign cfg_tx_prbs31_enable = prbs_q;
    assign cfg_rx_prbs31_enable = prbs_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign pass                 = pass_q;
    assign fail_code            = fail_code_q;
    assign err_total            = err_total_q;
    assign lock_cycles          = lock_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_phy_prbs_test_ctrl.sv
`default_nettype none
// ============================================================================
// tb_eth_phy_prbs_test_ctrl : table-driven bench for eth_phy_prbs_test_ctrl.
// Revision : 1.0
// ============================================================================
module tb_eth_phy_prbs_test_ctrl;

`ifdef PRBS_CTRL_EARLY_STOP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int NEVER = 1 << 30;

    logic       clk = 1'b0;
    logic       rx_rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       rx_block_lock = 1'b0;
    logic       rx_high_ber = 1'b0;
    logic [6:0] rx_error_count = '0;
    logic       sel_a = 1'b0;

    logic        a_txr, a_rxr, a_txp, a_rxp, a_busy, a_done, a_pass;
    logic [2:0]  a_fc;
    logic [31:0] a_err;
    logic [15:0] a_lock;
    logic        b_txr, b_rxr, b_txp, b_rxp, b_busy, b_done, b_pass;
    logic [2:0]  b_fc;
    logic [7:0]  b_err;
    logic [15:0] b_lock;

    always #5 clk = ~clk;

    eth_phy_prbs_test_ctrl u_dut_a (
        .rx_clk(clk), .rx_rst(rx_rst), .start(start & sel_a), .abort(abort),
        .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber), .rx_error_count(rx_error_count),
        .phy_tx_rst(a_txr), .phy_rx_rst(a_rxr), .cfg_tx_prbs31_enable(a_txp),
        .cfg_rx_prbs31_enable(a_rxp), .busy(a_busy), .done(a_done), .pass(a_pass),
        .fail_code(a_fc), .err_total(a_err), .lock_cycles(a_lock)
    );

    eth_phy_prbs_test_ctrl #(
        .LOCK_TIMEOUT(100), .WINDOW_BLOCKS(1000), .ERR_LIMIT(10), .COUNT_WIDTH(8)
    ) u_dut_b (
        .rx_clk(clk), .rx_rst(rx_rst), .start(start & ~sel_a), .abort(abort),
        .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber), .rx_error_count(rx_error_count),
        .phy_tx_rst(b_txr), .phy_rx_rst(b_rxr), .cfg_tx_prbs31_enable(b_txp),
        .cfg_rx_prbs31_enable(b_rxp), .busy(b_busy), .done(b_done), .pass(b_pass),
        .fail_code(b_fc), .err_total(b_err), .lock_cycles(b_lock)
    );

    wire        m_txr  = sel_a ? a_txr  : b_txr;
    wire        m_rxr  = sel_a ? a_rxr  : b_rxr;
    wire        m_txp  = sel_a ? a_txp  : b_txp;
    wire        m_rxp  = sel_a ? a_rxp  : b_rxp;
    wire        m_busy = sel_a ? a_busy : b_busy;
    wire        m_done = sel_a ? a_done : b_done;
    wire        m_pass = sel_a ? a_pass : b_pass;
    wire [2:0]  m_fc   = sel_a ? a_fc   : b_fc;
    wire [31:0] m_err  = sel_a ? a_err  : {24'd0, b_err};
    wire [15:0] m_lock = sel_a ? a_lock : b_lock;

    // Event edges k count rising edges from the one that samples start (k=0).
    typedef struct {
        string name;
        bit    on_a;
        int    lock_k, drop_k, ber_k, abort_k, start2_k;
        int    err_k0, err_n, err_val, noise_end;
        int    x_done_k, x_pass, x_fc, x_err, x_lock, x_prbs;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; rx_block_lock = 1'b0;
        rx_high_ber = 1'b0; rx_error_count = '0;
    endtask

    task automatic drive(input vec_t v, input int k);
        start         = (k == 0) || (k == v.start2_k);
        rx_block_lock = (k >= v.lock_k) && (k != v.drop_k);
        rx_high_ber   = (k == v.ber_k);
        abort         = (k == v.abort_k);
        if (k >= v.err_k0 && k < v.err_k0 + v.err_n) rx_error_count = 7'(v.err_val);
        else if (k < v.noise_end)                    rx_error_count = 7'd1;
        else                                         rx_error_count = 7'd0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "/phy_tx_rst"}, m_txr, 1);
        check({tag, "/phy_rx_rst"}, m_rxr, 1);
        check({tag, "/tx_prbs"}, m_txp, 0);
        check({tag, "/rx_prbs"}, m_rxp, 0);
        check({tag, "/busy"}, m_busy, 0);
        check({tag, "/done"}, m_done, 0);
        check({tag, "/pass"}, m_pass, 0);
        check({tag, "/fail_code"}, m_fc, 0);
        check({tag, "/err_total"}, m_err, 0);
        check({tag, "/lock_cycles"}, m_lock, 0);
    endtask

    task automatic run_vec(input vec_t v);
        vec_t x;
        int   got = -1;
        bit   prbs_seen = 1'b0;
        sel_a = v.on_a;
        sb_q.push_back(v);
        for (int k = 0; k <= v.x_done_k + 8; k++) begin
            drive(v, k);
            @(posedge clk); #1;
            if (m_txp || m_rxp) prbs_seen = 1'b1;
            if (k == 15) check({v.name, "/rst_held"}, m_txr & m_rxr, 1);
            if (k == 16) begin
                check({v.name, "/rst_release"}, m_txr | m_rxr, 0);
                check({v.name, "/busy"}, m_busy, 1);
            end
            if (m_done) begin
                got = k;
                break;
            end
        end
        idle_inputs();
        x = sb_q.pop_front();
        check({x.name, "/done_edge"}, got, x.x_done_k);
        check({x.name, "/pass"}, m_pass, x.x_pass);
        check({x.name, "/fail_code"}, m_fc, x.x_fc);
        check({x.name, "/err_total"}, m_err, x.x_err);
        check({x.name, "/lock_cycles"}, m_lock, x.x_lock);
        check({x.name, "/prbs_seen"}, prbs_seen, x.x_prbs);
        check({x.name, "/done_prbs_off"}, m_txp | m_rxp, 0);
        check({x.name, "/done_phy_rst_off"}, m_txr | m_rxr, 0);
        check({x.name, "/done_busy"}, m_busy, 0);
    endtask

    initial begin
        vec_t v;
        // name, on_a, lock_k, drop_k, ber_k, abort_k, start2_k, err_k0, err_n, err_val, noise_end,
        // done_k, pass, fc, err, lock, prbs
        vecs.push_back('{"a_full_clean", 1'b1, 22, -1, -1, -1, -1, -1, 0, 0, 87,
                         65622, 1, 0, 0, 6, 1});
        vecs.push_back('{"lock_timeout", 1'b0, NEVER, -1, -1, -1, -1, -1, 0, 0, 0,
                         116, 0, 1, 0, 100, 0});
        vecs.push_back('{"limit_exact", 1'b0, 22, -1, -1, -1, 500, 187, 5, 2, 87,
                         1086, 1, 0, 10, 6, 1});
        vecs.push_back('{"err_limit", 1'b0, 22, -1, -1, -1, -1, 187, 5, 3, 0,
                         EARLY ? 190 : 1086, 0, 3, EARLY ? 12 : 15, 6, 1});
        vecs.push_back('{"saturate", 1'b0, 22, -1, -1, -1, -1, 87, 3, 127, 0,
                         EARLY ? 87 : 1086, 0, 3, EARLY ? 127 : 255, 6, 1});
        vecs.push_back('{"lock_drop", 1'b0, 22, 287, -1, -1, -1, 287, 1, 4, 0,
                         287, 0, 2, 4, 6, 1});
        vecs.push_back('{"drop_and_ber", 1'b0, 22, 387, 387, -1, -1, -1, 0, 0, 0,
                         387, 0, 2, 0, 6, 1});
        vecs.push_back('{"high_ber", 1'b0, 22, -1, 137, -1, -1, -1, 0, 0, 0,
                         137, 0, 5, 0, 6, 1});
        vecs.push_back('{"abort_settle", 1'b0, 22, -1, -1, 33, -1, -1, 0, 0, 0,
                         33, 0, 4, 0, 6, 1});
        vecs.push_back('{"restart_clean", 1'b0, 22, -1, -1, -1, -1, -1, 0, 0, 0,
                         1086, 1, 0, 0, 6, 1});
        vecs.push_back('{"settle_drop", 1'b0, 22, 40, -1, -1, -1, -1, 0, 0, 0,
                         40, 0, 2, 0, 6, 1});
        vecs.push_back('{"lock_first", 1'b0, 0, -1, -1, -1, -1, -1, 0, 0, 0,
                         1081, 1, 0, 0, 1, 1});
        vecs.push_back('{"lock_at_timeout", 1'b0, 116, -1, -1, -1, -1, -1, 0, 0, 0,
                         1180, 1, 0, 0, 100, 1});

        rx_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por_b");
        sel_a = 1'b1;
        check_reset_vals("por_a");
        rx_rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Abort while DONE must leave the last result untouched.
        sel_a = 1'b0;
        abort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_in_done/done", m_done, 1);
        check("abort_in_done/pass", m_pass, 1);
        check("abort_in_done/fail_code", m_fc, 0);

        // Reset at MEASURE cycle 50 discards a partial result.
        v = '{"rst_mid", 1'b0, 22, -1, -1, -1, -1, 87, 5, 1, 0, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k <= 136; k++) begin
            drive(v, k);
            @(posedge clk); #1;
        end
        check("rst_mid/err_before", m_err, 5);
        check("rst_mid/busy_before", m_busy, 1);
        idle_inputs();
        rx_rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("rst_mid");
        rx_rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
